// File: rtl/alu_chain_ctrl.sv
// alu_chain_ctrl: runs ANCHO*PALABRAS-bit operations through one ANCHO-bit ALU slice,
// one slice per clock, LSB slice first. Add/sub chain the slice flag into the next
// slice. The wide result, completion and error status go back through a start/done
// handshake. All outputs, including the ALU-side drives, come from registers.
module alu_chain_ctrl #(
  parameter int ANCHO    = 4,
  parameter int PALABRAS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [3:0]                op_i,
  input  logic [ANCHO*PALABRAS-1:0] a_i,
  input  logic [ANCHO*PALABRAS-1:0] b_i,
  input  logic                      cin_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [ANCHO*PALABRAS-1:0] result_o,
  output logic                      flag_o,
  output logic                      zero_o,
  output logic [ANCHO-1:0]          alu_a_o,
  output logic [ANCHO-1:0]          alu_b_o,
  output logic                      alu_flagin_o,
  output logic [3:0]                alu_control_o,
  input  logic [ANCHO-1:0]          alu_result_i,
  input  logic                      alu_flags_i,
  input  logic                      alu_zero_i
);

  localparam int W  = ANCHO * PALABRAS;
  localparam int KW = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PALABRAS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes the attached ALU implements and this controller will sequence.
  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7: op_supported = 1'b1;
      default:                            op_supported = 1'b0;
    endcase
  endfunction

  // Only add and sub carry a flag from one slice into the next.
  function automatic logic op_is_arith(input logic [3:0] op);
    case (op)
      4'h2, 4'h6: op_is_arith = 1'b1;
      default:    op_is_arith = 1'b0;
    endcase
  endfunction

  // Pick slice idx out of a wide operand.
  function automatic logic [ANCHO-1:0] slice_of(input logic [W-1:0] v, input logic [KW-1:0] idx);
    slice_of = v[idx*ANCHO +: ANCHO];
  endfunction

  state_t            state_r;
  logic [KW-1:0]     k_r;
  logic [3:0]        op_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              zacc_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [W-1:0]      result_r;
  logic              flag_r;
  logic              zero_r;
  logic [ANCHO-1:0]  alu_a_r;
  logic [ANCHO-1:0]  alu_b_r;
  logic              alu_flagin_r;
  logic [3:0]        alu_control_r;

  logic [KW-1:0]     k_next_s;
  logic              flag_next_s;
  logic              zacc_next_s;

  // Next slice index, gated slice flag and running zero accumulation.
  always_comb begin
    k_next_s    = k_r + KW'(1);
    zacc_next_s = zacc_r & alu_zero_i;
    if (op_is_arith(op_r)) begin
      flag_next_s = alu_flags_i;
    end else begin
      flag_next_s = 1'b0;
    end
  end

  // Sequencer: accept a request, walk the slices, then pulse done for one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r       <= ST_IDLE;
      k_r           <= '0;
      op_r          <= 4'h0;
      a_r           <= '0;
      b_r           <= '0;
      zacc_r        <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      result_r      <= '0;
      flag_r        <= 1'b0;
      zero_r        <= 1'b0;
      alu_a_r       <= '0;
      alu_b_r       <= '0;
      alu_flagin_r  <= 1'b0;
      alu_control_r <= 4'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          err_r  <= 1'b0;
          if (start_i) begin
            op_r     <= op_i;
            a_r      <= a_i;
            b_r      <= b_i;
            busy_r   <= 1'b1;
            result_r <= '0;
            if (op_supported(op_i)) begin
              state_r       <= ST_RUN;
              k_r           <= '0;
              zacc_r        <= 1'b1;
              alu_a_r       <= a_i[ANCHO-1:0];
              alu_b_r       <= b_i[ANCHO-1:0];
              alu_control_r <= op_i;
              alu_flagin_r  <= op_is_arith(op_i) ? cin_i : 1'b0;
            end else begin
              // Rejected opcode: straight to the completion cycle, never touches the ALU.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              flag_r  <= 1'b0;
              zero_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_RUN: begin
          result_r[k_r*ANCHO +: ANCHO] <= alu_result_i;
          zacc_r                       <= zacc_next_s;
          if (k_r == K_LAST) begin
            state_r       <= ST_DONE;
            done_r        <= 1'b1;
            err_r         <= 1'b0;
            flag_r        <= flag_next_s;
            zero_r        <= zacc_next_s;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
            alu_flagin_r  <= 1'b0;
            alu_control_r <= 4'h0;
          end else begin
            // The flag coming back from this slice is next slice's flag input.
            k_r          <= k_next_s;
            alu_a_r      <= slice_of(a_r, k_next_s);
            alu_b_r      <= slice_of(b_r, k_next_s);
            alu_flagin_r <= flag_next_s;
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
        end

        default: begin
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          done_r        <= 1'b0;
          err_r         <= 1'b0;
          alu_a_r       <= '0;
          alu_b_r       <= '0;
          alu_flagin_r  <= 1'b0;
          alu_control_r <= 4'h0;
        end
      endcase
    end
  end

  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign err_o         = err_r;
  assign result_o      = result_r;
  assign flag_o        = flag_r;
  assign zero_o        = zero_r;
  assign alu_a_o       = alu_a_r;
  assign alu_b_o       = alu_b_r;
  assign alu_flagin_o  = alu_flagin_r;
  assign alu_control_o = alu_control_r;

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Bench for alu_chain_ctrl: behavioural single-slice ALU on the ALU side, a
// transaction-level reference model, a per-cycle compare process, directed
// literal cases and a randomized phase.
module tb_alu_chain_ctrl;

  localparam int ANCHO    = 4;
  localparam int PALABRAS = 4;
  localparam int W        = ANCHO * PALABRAS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       op = 4'h0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             cin = 1'b0;
  logic             busy, done, err, flag, zero;
  logic [W-1:0]     result;
  logic [ANCHO-1:0] alu_a, alu_b, alu_result;
  logic             alu_flagin, alu_flags, alu_zero;
  logic [3:0]       alu_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_chain_ctrl #(.ANCHO(ANCHO), .PALABRAS(PALABRAS)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .cin_i(cin), .busy_o(busy), .done_o(done), .err_o(err), .result_o(result),
    .flag_o(flag), .zero_o(zero), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_flagin_o(alu_flagin), .alu_control_o(alu_ctrl),
    .alu_result_i(alu_result), .alu_flags_i(alu_flags), .alu_zero_i(alu_zero)
  );

  // Single-slice ALU with unsigned carry-out / borrow-out; returns {zero, flag, result}.
  function automatic logic [ANCHO+1:0] alu_fn(input logic [ANCHO-1:0] x, input logic [ANCHO-1:0] y,
                                               input logic fi, input logic [3:0] o);
    logic [ANCHO:0] t;
    t = '0;
    case (o)
      4'h0: t = {1'b0, x & y};
      4'h1: t = {1'b0, x | y};
      4'h2: t = {1'b0, x} + {1'b0, y} + {{ANCHO{1'b0}}, fi};
      4'h5: t = {1'b0, ~x};
      4'h6: t = {1'b0, x} - {1'b0, y} - {{ANCHO{1'b0}}, fi};
      4'h7: t = {1'b0, x ^ y};
      default: t = '0;
    endcase
    return {(t[ANCHO-1:0] == '0), t[ANCHO], t[ANCHO-1:0]};
  endfunction

  assign {alu_zero, alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_flagin, alu_ctrl);

  function automatic logic supp(input logic [3:0] o);
    return (o == 4'h0) || (o == 4'h1) || (o == 4'h2) || (o == 4'h5) || (o == 4'h6) || (o == 4'h7);
  endfunction

  function automatic logic arith(input logic [3:0] o);
    return (o == 4'h2) || (o == 4'h6);
  endfunction

  // ---------------- reference model (transaction level) ----------------
  int           left = 0;          // busy cycles remaining, done in the last one
  logic [3:0]   m_op = 4'h0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_cin = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_flag = 1'b0, m_zero = 1'b0, m_err = 1'b0;

  // Carry/borrow that must enter slice j, from plain arithmetic on the low j slices.
  function automatic logic carry_in(input int j);
    longint mask, la, lb;
    mask = (longint'(1) << (j * ANCHO)) - 1;
    la   = longint'(m_a) & mask;
    lb   = longint'(m_b) & mask;
    if (m_op == 4'h2) return ((la + lb + longint'(m_cin)) >> (j * ANCHO)) & 1;
    return la < (lb + longint'(m_cin));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left = 0; m_res = '0; m_flag = 1'b0; m_zero = 1'b0; m_err = 1'b0;
    end else if (left > 0) begin
      left = left - 1;
    end else if (start) begin
      logic [W:0] t;
      m_op = op; m_a = a; m_b = b; m_cin = cin;
      t = '0;
      case (op)
        4'h0: t = {1'b0, a & b};
        4'h1: t = {1'b0, a | b};
        4'h2: t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        4'h5: t = {1'b0, ~a};
        4'h6: t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        4'h7: t = {1'b0, a ^ b};
        default: t = '0;
      endcase
      m_res  = t[W-1:0];
      m_flag = arith(op) ? t[W] : 1'b0;
      m_zero = supp(op) ? (t[W-1:0] == '0) : 1'b0;
      m_err  = !supp(op);
      left   = supp(op) ? PALABRAS + 1 : 1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int j;
      logic e_done;
      e_done = (left == 1);
      chk("busy", W'(busy), W'(left > 0));
      chk("done", W'(done), W'(e_done));
      chk("err", W'(err), W'(e_done && m_err));
      if (left == 0 || e_done) begin
        chk("result", result, m_res);
        chk("flag", W'(flag), W'(m_flag));
        chk("zero", W'(zero), W'(m_zero));
      end
      if (left > 1 && supp(m_op)) begin
        j = PALABRAS + 1 - left;
        chk("alu_a", W'(alu_a), W'(m_a[j*ANCHO +: ANCHO]));
        chk("alu_b", W'(alu_b), W'(m_b[j*ANCHO +: ANCHO]));
        chk("alu_ctrl", W'(alu_ctrl), W'(m_op));
        chk("alu_flagin", W'(alu_flagin), W'(arith(m_op) ? carry_in(j) : 1'b0));
      end else begin
        chk("alu_idle", {alu_a, alu_b, alu_flagin, alu_ctrl}, '0);
      end
    end
  end

  // Wait (bounded) for idle, issue one request, and pin the outcome to literals.
  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic xc, input logic [W-1:0] e_res,
                        input logic e_flag, input logic e_zero, input logic e_err,
                        input int e_lat, input logic chk_fi, input logic [3:0] e_fi);
    int n;
    logic [3:0] fi_seen;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    start = 1'b1; op = o; a = xa; b = xb; cin = xc;
    @(posedge clk); #1 start = 1'b0;
    fi_seen = 4'h0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
      if (i <= 4) fi_seen[i-1] = alu_flagin;
    end
    chk({name, "_latency"}, W'(n), W'(e_lat));
    chk({name, "_result"}, result, e_res);
    chk({name, "_flag"}, W'(flag), W'(e_flag));
    chk({name, "_zero"}, W'(zero), W'(e_zero));
    chk({name, "_err"}, W'(err), W'(e_err));
    if (chk_fi) chk({name, "_flagin_seq"}, W'(fi_seen), W'(e_fi));
  endtask

  initial begin
    #3;
    chk("rst_outputs", {busy, done, err, flag, zero, result}, '0);
    chk("rst_alu", {alu_a, alu_b, alu_flagin, alu_ctrl}, '0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    run_op("add",     4'h2, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 5, 1'b1, 4'b0110);
    run_op("add_ovf", 4'h2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 5, 1'b0, 4'h0);
    run_op("add_cin", 4'h2, 16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0, 5, 1'b0, 4'h0);
    run_op("sub",     4'h6, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0, 5, 1'b0, 4'h0);
    run_op("sub_brw", 4'h6, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 5, 1'b0, 4'h0);
    run_op("xor",     4'h7, 16'hA5A5, 16'hFFFF, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 5, 1'b1, 4'h0);
    run_op("not",     4'h5, 16'hFFFF, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 5, 1'b1, 4'h0);
    run_op("unsup",   4'h8, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0, 4'h0);

    // start held high: accepts only at idle edges, the model tracks each done
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = (i % 2 == 0) ? 4'h2 : 4'hC; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    // reset during slice 2 aborts the operation
    while (busy) @(negedge clk);
    start = 1'b1; op = 4'h2; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, done, err, flag, zero, result}, '0);
    chk("midrst_alu", {alu_a, alu_b, alu_flagin, alu_ctrl}, '0);
    @(negedge clk);
    chk("midrst_no_done", W'(done), '0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 4'h2, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 5, 1'b0, 4'h0);

    // randomized phase, start toggling freely including while busy
    for (int i = 0; i < 400; i++) begin
      start = 1'($urandom_range(0, 1));
      op    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7));
      a     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      b     = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_chain_ctrl.md
Name: alu_chain_ctrl

Overview:
Multi-cycle controller that drives the team's single-slice ALU from the operand side. It runs wide operations (ANCHO*PALABRAS bits) as a sequence of ANCHO-bit slices, one slice per clock, LSB slice first. For add/sub it chains each slice's carry/borrow flag into the next slice's flag input. It collects the slice results into a wide result and reports completion to the requester through a start/done handshake.

Parameters:
ANCHO, 4, slice width; must match the attached ALU's ANCHO
PALABRAS, 4, number of slices per operation (>=2); total width W = ANCHO*PALABRAS

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  request strobe; accepted only in IDLE
op_i  in  4  ALU opcode; supported: 0x0 and, 0x1 or, 0x2 add, 0x5 not(A), 0x6 sub, 0x7 xor
a_i  in  W  operand A
b_i  in  W  operand B
cin_i  in  1  carry/borrow into slice 0 (add/sub only)
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  high with done_o when op was unsupported
result_o  out  W  wide result, held until next accepted start
flag_o  out  1  carry/borrow out of the top slice; 0 for logic ops
zero_o  out  1  1 when every slice reported zero
alu_a_o  out  ANCHO  to ALU operand A
alu_b_o  out  ANCHO  to ALU operand B
alu_flagin_o  out  1  to ALU flag input
alu_control_o  out  4  to ALU opcode
alu_result_i  in  ANCHO  from ALU result
alu_flags_i  in  1  from ALU flag
alu_zero_i  in  1  from ALU zero

Behaviour:
- Reset (asynchronous, active-low; takes effect immediately): state=IDLE. busy_o, done_o, err_o, flag_o, zero_o = 0. result_o = 0. All alu_*_o = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE with start_i=1 at an edge: latch op_i, a_i, b_i and cin_i.
  - Supported op: go to RUN with slice index k=0, set zero accumulator to 1, clear result.
  - Unsupported op: go to DONE with err=1, result_o=0, flag_o=0, zero_o=0; no RUN cycles.
- RUN, slice k (combinational to ALU):
  - alu_a_o = A_q[k*ANCHO +: ANCHO], alu_b_o = B_q[k*ANCHO +: ANCHO].
  - alu_control_o = op_q.
  - alu_flagin_o = cin_q when k=0, else carry_q; forced to 0 for ops 0x0, 0x1, 0x5, 0x7.
- RUN, at the edge ending slice k:
  - result slice k <= alu_result_i.
  - carry_q <= alu_flags_i.
  - zero accumulator <= zero accumulator & alu_zero_i.
  - k increments; after k=PALABRAS-1, go to DONE.
- DONE (exactly one cycle): done_o=1, err_o=err, flag_o=carry_q (0 for logic ops), zero_o=accumulator; next state IDLE. result_o, flag_o and zero_o hold after DONE.
- Latency: accept edge T; RUN occupies cycles T+1..T+PALABRAS; done_o is high in cycle T+PALABRAS+1. Unsupported op: done_o is high in cycle T+1.
- In IDLE and DONE, all alu_*_o are driven to 0.
- start_i is ignored while busy_o=1, including the DONE cycle. Back-to-back: the earliest next accept is the edge after DONE.
- Flag semantics: the controller never modifies alu_flags_i; it propagates the flag verbatim. Correct wide carry/borrow requires unsigned carry-out (add) and borrow-out (sub) from the ALU.
- Reset asserted mid-RUN: aborts the operation, no done_o, all outputs at reset values.

Test Plan:
(ANCHO=4, PALABRAS=4; ALU side driven by a behavioural model with unsigned carry/borrow out.)
- Add: a=0x00FF, b=0x0001, cin=0, op=0x2 -> done_o exactly 5 cycles after accept; result_o=0x0100, flag_o=0, zero_o=0, err_o=0; alu_flagin_o = 0,1,1,0 across slices 0..3.
- Add overflow: 0xFFFF+0x0001, cin=0 -> result_o=0x0000, flag_o=1, zero_o=1. Add 0x1234+0x0000 with cin=1 -> result_o=0x1235, flag_o=0.
- Sub: 0x0100-0x0001 -> result_o=0x00FF, flag_o=0. Sub 0x0000-0x0001 -> result_o=0xFFFF, flag_o=1.
- Logic ops: xor 0xA5A5^0xFFFF -> result_o=0x5A5A, flag_o=0; not(A) with a=0xFFFF -> result_o=0x0000, zero_o=1; alu_flagin_o=0 in every RUN cycle.
- Unsupported op=0x8 -> busy_o for 1 cycle, then done_o=1 and err_o=1 one cycle after accept; result_o=0x0000; alu_control_o stays 0.
- start_i held high continuously -> accepts at IDLE edges only, one done_o per operation. Deassert rst_n_i during slice 2 -> busy_o=0, result_o=0 immediately, no done_o; the next start completes normally.
